uart_txd_fifo: RTL and testbench

Parametrised UART transmitter. It replaces the fixed 8N1 transmitter and its external baud-tick scheme with the following:
- Configurable data width, parity, stop bits and bit order.
- Internal baud divider.
- valid/ready input handshake feeding a small TX FIFO.
- Back-to-back frames with no idle gap.

It sits between a byte-producing client (command/response logic) and the RS-232 TXD pin.

---
 rtl/uart_txd_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_txd_fifo.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_txd_fifo.sv
// UART transmitter with a small TX FIFO, internal baud divider and
// configurable frame format. Frames leave back-to-back while words remain queued.
module uart_txd_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned LSB_FIRST    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_valid,
    input  logic [DATA_BITS-1:0]               i_data,
    output logic                               o_ready,
    output logic                               o_rs232_txd,
    output logic                               o_busy,
    output logic                               o_tx_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    // Reject parameter sets the datapath cannot represent
    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
            STOP_BITS < 1 || STOP_BITS > 2 || LSB_FIRST > 1 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("uart_txd_fifo: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 frame_end;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;
    logic                 next_bit;
    logic [DATA_BITS-1:0] shifted;

    assign full         = (count == CNT_W'(FIFO_DEPTH));
    assign o_ready      = !full;
    assign o_fifo_count = count;
    assign head         = mem[rd_ptr];
    // Even parity bit is the XOR of the data; odd parity is its complement
    assign head_par     = (PARITY == 2) ? ^head : ~^head;
    assign bit_end      = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign frame_end    = (state == S_STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
    assign push         = i_valid && !full;
    assign pop          = (count != '0) && ((state == S_IDLE) || frame_end);
    assign next_bit     = (LSB_FIRST != 0) ? shreg[0] : shreg[DATA_BITS-1];
    assign shifted      = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // FIFO pointers and occupancy; push and pop on the same edge cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame FSM: baud timing, bit sequencing and registered line outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            o_rs232_txd <= 1'b1;
            o_busy      <= 1'b0;
            o_tx_done   <= 1'b0;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shreg       <= '0;
            par_bit     <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            if (state != S_IDLE) begin
                baud_cnt <= bit_end ? '0 : baud_cnt + BAUD_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state       <= S_START;
                        o_rs232_txd <= 1'b0;
                        o_busy      <= 1'b1;
                        shreg       <= head;
                        par_bit     <= head_par;
                        baud_cnt    <= '0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state       <= S_DATA;
                        o_rs232_txd <= next_bit;
                        shreg       <= shifted;
                        bit_idx     <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                state       <= S_PARITY;
                                o_rs232_txd <= par_bit;
                            end else begin
                                state       <= S_STOP;
                                o_rs232_txd <= 1'b1;
                                stop_idx    <= 1'b0;
                            end
                        end else begin
                            o_rs232_txd <= next_bit;
                            shreg       <= shifted;
                            bit_idx     <= bit_idx + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state       <= S_STOP;
                        o_rs232_txd <= 1'b1;
                        stop_idx    <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (frame_end) begin
                        o_tx_done <= 1'b1;
                        if (pop) begin
                            // Next word starts immediately, no idle gap
                            state       <= S_START;
                            o_rs232_txd <= 1'b0;
                            shreg       <= head;
                            par_bit     <= head_par;
                        end else begin
                            state       <= S_IDLE;
                            o_rs232_txd <= 1'b1;
                            o_busy      <= 1'b0;
                        end
                    end else if (bit_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    o_rs232_txd <= 1'b1;
                    o_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txd_fifo.sv
// Self-checking bench for uart_txd_fifo: four instances with different frame
// formats, checked cycle by cycle against a bit-list model of each frame.
`timescale 1ns/1ps
module tb_uart_txd_fifo;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] txd;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] dat [4];
    logic [2:0] cnt [4];

    int checks = 0;
    int errors = 0;

    // Frame format of each instance: data bits, parity, stop bits, lsb-first
    int P_DB[4]   = '{8, 8, 8, 5};
    int P_PAR[4]  = '{0, 2, 1, 0};
    int P_STOP[4] = '{1, 1, 1, 2};
    int P_LSB[4]  = '{1, 1, 1, 0};

    int exp_bits[$];

    always #5 clk = ~clk;

    uart_txd_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                    .LSB_FIRST(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .i_valid(vld[0]), .i_data(dat[0]),
        .o_ready(rdy[0]), .o_rs232_txd(txd[0]), .o_busy(busy[0]),
        .o_tx_done(done[0]), .o_fifo_count(cnt[0]));

    uart_txd_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                    .LSB_FIRST(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .i_valid(vld[1]), .i_data(dat[1]),
        .o_ready(rdy[1]), .o_rs232_txd(txd[1]), .o_busy(busy[1]),
        .o_tx_done(done[1]), .o_fifo_count(cnt[1]));

    uart_txd_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                    .LSB_FIRST(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .i_valid(vld[2]), .i_data(dat[2]),
        .o_ready(rdy[2]), .o_rs232_txd(txd[2]), .o_busy(busy[2]),
        .o_tx_done(done[2]), .o_fifo_count(cnt[2]));

    uart_txd_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2),
                    .LSB_FIRST(0), .FIFO_DEPTH(4)) u_5n2m (
        .clk(clk), .rst(rst), .i_valid(vld[3]), .i_data(dat[3][4:0]),
        .o_ready(rdy[3]), .o_rs232_txd(txd[3]), .o_busy(busy[3]),
        .o_tx_done(done[3]), .o_fifo_count(cnt[3]));

    // Reference model: append one frame's line bits for instance s
    task automatic add_frame(input int s, input int w);
        int ones;
        int b;
        ones = 0;
        exp_bits.push_back(0);
        for (int i = 0; i < P_DB[s]; i++) begin
            b = (P_LSB[s] != 0) ? ((w >> i) & 1) : ((w >> (P_DB[s] - 1 - i)) & 1);
            ones += b;
            exp_bits.push_back(b);
        end
        if (P_PAR[s] == 1) exp_bits.push_back(((ones % 2) == 0) ? 1 : 0);
        else if (P_PAR[s] == 2) exp_bits.push_back(ones % 2);
        for (int i = 0; i < P_STOP[s]; i++) exp_bits.push_back(1);
    endtask

    function automatic int frame_bits(input int s);
        return 1 + P_DB[s] + ((P_PAR[s] != 0) ? 1 : 0) + P_STOP[s];
    endfunction

    // Drive single-cycle pushes at the given edges (edge 0 = next posedge)
    task automatic drive_sched(input int s, input int words[$], input int edges[$]);
        int e;
        int k;
        e = 0;
        k = 0;
        while (k < words.size()) begin
            if (edges[k] == e) begin
                vld[s] = 1'b1;
                dat[s] = 8'(words[k]);
                k++;
            end else begin
                vld[s] = 1'b0;
                dat[s] = 8'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            e++;
        end
        vld[s] = 1'b0;
        dat[s] = 8'($urandom);
    endtask

    // Compare the line against exp_bits from the first pop edge (edge 1) on
    task automatic check_stream(input int s, input string tag);
        int   flen;
        int   n;
        logic ed;
        flen = frame_bits(s) * CPB;
        n    = exp_bits.size() * CPB;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (txd[s] !== 1'b1 || busy[s] !== 1'b0) begin
            errors++;
            $display("FAIL %s pre_start: txd=%b busy=%b, required txd=1 busy=0", tag, txd[s], busy[s]);
        end
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            checks++;
            if (txd[s] !== 1'(exp_bits[j / CPB])) begin
                errors++;
                $display("FAIL %s line cycle %0d: txd=%b, required %0d", tag, j, txd[s], exp_bits[j / CPB]);
            end
            ed = (j > 0) && ((j % flen) == 0);
            checks++;
            if (done[s] !== ed || busy[s] !== 1'b1) begin
                errors++;
                $display("FAIL %s status cycle %0d: done=%b busy=%b, required done=%b busy=1", tag, j, done[s], busy[s], ed);
            end
        end
        @(negedge clk);
        checks++;
        if (done[s] !== 1'b1 || busy[s] !== 1'b0 || txd[s] !== 1'b1 || cnt[s] !== 3'd0) begin
            errors++;
            $display("FAIL %s end: done=%b busy=%b txd=%b count=%0d, required 1/0/1/0", tag, done[s], busy[s], txd[s], cnt[s]);
        end
        @(negedge clk);
        checks++;
        if (done[s] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_width: done=%b, required 0", tag, done[s]);
        end
        exp_bits.delete();
    endtask

    task automatic send_frames(input int s, input int words[$], input int edges[$], input string tag);
        foreach (words[i]) add_frame(s, words[i]);
        fork
            drive_sched(s, words, edges);
            check_stream(s, tag);
        join
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = '0;
        for (int s = 0; s < 4; s++) dat[s] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (txd[s] !== 1'b1 || busy[s] !== 1'b0 || done[s] !== 1'b0 ||
                cnt[s] !== 3'd0 || rdy[s] !== 1'b1) begin
                errors++;
                $display("FAIL reset dut%0d: txd=%b busy=%b done=%b count=%0d ready=%b, required 1/0/0/0/1",
                         s, txd[s], busy[s], done[s], cnt[s], rdy[s]);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_8n1();
        int w[$];
        int e[$];
        w = '{'hA5};
        e = '{0};
        send_frames(0, w, e, "8n1_a5");
    endtask

    task automatic test_parity();
        int w[$];
        int e[$];
        e = '{0};
        w = '{'h07};
        send_frames(1, w, e, "even_07");
        send_frames(2, w, e, "odd_07");
        for (int i = 0; i < 3; i++) begin
            w = '{int'($urandom_range(0, 255))};
            send_frames(1 + (i % 2), w, e, "parity_rand");
        end
    endtask

    task automatic test_msb_5bit();
        int w[$];
        int e[$];
        e = '{0};
        w = '{'h13};
        send_frames(3, w, e, "5n2_msb_13");
        w = '{int'($urandom_range(0, 31))};
        send_frames(3, w, e, "5n2_msb_rand");
    endtask

    task automatic test_random();
        int w[$];
        int e[$];
        int s;
        e = '{0};
        for (int i = 0; i < 6; i++) begin
            s = int'($urandom_range(0, 3));
            w = '{int'($urandom_range(0, (1 << P_DB[s]) - 1))};
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_frames(s, w, e, "random");
        end
    endtask

    task automatic test_back_to_back();
        int w[$];
        int e[$];
        int s;
        for (int i = 0; i < 2; i++) begin
            s = int'($urandom_range(0, 3));
            w = '{int'($urandom_range(0, (1 << P_DB[s]) - 1)), int'($urandom_range(0, (1 << P_DB[s]) - 1)),
                  int'($urandom_range(0, (1 << P_DB[s]) - 1))};
            e = '{0, 1, 2};
            send_frames(s, w, e, "back_to_back");
        end
    endtask

    task automatic test_fifo_full();
        for (int i = 1; i <= 5; i++) add_frame(0, i);
        fork
            begin : drv
                int   idx;
                int   acc;
                logic will;
                idx = 0;
                acc = 0;
                for (int e = 0; e < 9; e++) begin
                    vld[0] = 1'b1;
                    dat[0] = 8'(idx + 1);
                    will   = rdy[0];
                    @(posedge clk);
                    if (will) begin
                        idx++;
                        acc++;
                    end
                    @(negedge clk);
                end
                checks++;
                if (acc !== 5 || cnt[0] !== 3'd4 || rdy[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL fifo_full: accepted=%0d count=%0d ready=%b, required 5/4/0", acc, cnt[0], rdy[0]);
                end
                vld[0] = 1'b0;
            end
            check_stream(0, "fifo_full");
        join
    endtask

    task automatic test_push_pop();
        int w[$];
        int e[$];
        for (int i = 0; i < 4; i++) w.push_back(int'($urandom_range(0, 255)));
        e = '{0, 1, 2, 41};
        foreach (w[i]) add_frame(0, w[i]);
        fork
            drive_sched(0, w, e);
            check_stream(0, "push_pop");
            begin
                repeat (41) @(posedge clk);
                @(negedge clk);
                checks++;
                if (cnt[0] !== 3'd2) begin
                    errors++;
                    $display("FAIL push_pop pre: count=%0d, required 2", cnt[0]);
                end
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (cnt[0] !== 3'd2 || rdy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL push_pop same_edge: count=%0d ready=%b, required 2/1", cnt[0], rdy[0]);
                end
            end
        join
    endtask

    task automatic test_reset_midframe();
        int w[$];
        int e[$];
        for (int i = 0; i < 3; i++) w.push_back(int'($urandom_range(0, 255)));
        e = '{0, 1, 2};
        drive_sched(0, w, e);
        // now just after edge 2; bit 3 occupies edges 17..20
        repeat (16) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || cnt[0] !== 3'd2 || txd[0] !== 1'(w[0] >> 3)) begin
            errors++;
            $display("FAIL midframe: busy=%b count=%0d txd=%b, required 1/2/%0d", busy[0], cnt[0], txd[0], (w[0] >> 3) & 1);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 3'd0 || rdy[0] !== 1'b1 || done[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort: txd=%b busy=%b count=%0d ready=%b done=%b, required 1/0/0/1/0",
                     txd[0], busy[0], cnt[0], rdy[0], done[0]);
        end
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            checks++;
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
                errors++;
                $display("FAIL after_abort cycle %0d: txd=%b busy=%b done=%b, required 1/0/0", j, txd[0], busy[0], done[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_msb_5bit();
        test_random();
        test_back_to_back();
        test_fifo_full();
        test_push_pop();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
